// File: rtl/parking_pkg.sv
// Shared types and helpers for the parking lot controller: status/op codes,
// FSM states and a constant-foldable ceil(log2) used for port and counter widths.
package parking_pkg;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_FULL      = 2'd1,
        ST_DUP       = 2'd2,
        ST_NOT_FOUND = 2'd3
    } status_e;

    typedef enum logic {
        OP_ENTRY = 1'b0,
        OP_EXIT  = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_COMMIT
    } state_e;

    // Smallest r with 2**r >= value; clog2(1) == 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/parking_timebase.sv
// Free-running timebase: a 0..TICK_DIV-1 prescaler advances a counter that
// wraps naturally modulo 2**TIME_W.
module parking_timebase
    import parking_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter int TIME_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic [TIME_W-1:0] current_time
);

    localparam int PRE_W = (TICK_DIV > 1) ? clog2(TICK_DIV) : 1;

    logic [PRE_W-1:0]  prescale_q;
    logic [TIME_W-1:0] time_q;
    logic              tick;

    assign tick         = (prescale_q == PRE_W'(TICK_DIV - 1));
    assign current_time = time_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale_q <= '0;
            time_q     <= '0;
        end else begin
            prescale_q <= tick ? '0 : prescale_q + PRE_W'(1);
            if (tick) time_q <= time_q + TIME_W'(1);
        end
    end

endmodule

// File: rtl/parking_lot_ctrl.sv
// Multi-slot parking controller: accepts entry/exit requests, scans the slot
// table one slot per cycle, then commits the update and reports status and fee.
module parking_lot_ctrl
    import parking_pkg::*;
#(
    parameter int NUM_SLOTS  = 8,
    parameter int ID_W       = 4,
    parameter int TIME_W     = 32,
    parameter int COST_W     = 32,
    parameter int TICK_DIV   = 1000,
    parameter int RATE       = 5,
    parameter int MIN_CHARGE = 10
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_op,
    input  logic [ID_W-1:0]                   car_id,
    output logic                              resp_valid,
    output logic [1:0]                        resp_status,
    output logic                              write_enable,
    output logic                              read_enable,
    output logic [TIME_W-1:0]                 Entry_time,
    output logic [COST_W-1:0]                 Ccost,
    output logic [TIME_W-1:0]                 current_time,
    output logic [clog2(NUM_SLOTS+1)-1:0]     occupancy,
    output logic                              full,
    output logic                              empty
);

    localparam int IDX_W  = clog2(NUM_SLOTS);
    localparam int OCC_W  = clog2(NUM_SLOTS + 1);
    localparam int PROD_W = TIME_W + clog2(RATE + 1);
    localparam int WIDE_W = ((PROD_W > COST_W) ? PROD_W : COST_W) + 1;
    localparam logic [WIDE_W-1:0] MAX_COST  = {{(WIDE_W-COST_W){1'b0}}, {COST_W{1'b1}}};
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_SLOTS - 1);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    op_e                   op_q, op_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [TIME_W-1:0]     cap_time_q, cap_time_d;
    logic                  free_found_q, free_found_d;
    logic [IDX_W-1:0]      free_idx_q, free_idx_d;
    logic                  match_found_q, match_found_d;
    logic [IDX_W-1:0]      match_idx_q, match_idx_d;
    logic [NUM_SLOTS-1:0]  slot_valid_q, slot_valid_d;
    logic [ID_W-1:0]       slot_id_q   [NUM_SLOTS];
    logic [TIME_W-1:0]     slot_time_q [NUM_SLOTS];
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  full_q, full_d, empty_q, empty_d;
    logic                  resp_valid_q, resp_valid_d;
    status_e               status_q, status_d;
    logic                  we_q, we_d, re_q, re_d;
    logic [TIME_W-1:0]     entry_time_q, entry_time_d;
    logic [COST_W-1:0]     cost_q, cost_d;
    logic                  slot_wr;
    logic [TIME_W-1:0]     elapsed;
    logic [PROD_W-1:0]     product;
    logic [WIDE_W-1:0]     fee_wide;

    parking_timebase #(
        .TICK_DIV (TICK_DIV),
        .TIME_W   (TIME_W)
    ) u_timebase (
        .clk          (clk),
        .reset        (reset),
        .current_time (current_time)
    );

    assign req_ready    = (state_q == S_IDLE);
    assign resp_valid   = resp_valid_q;
    assign resp_status  = status_q;
    assign write_enable = we_q;
    assign read_enable  = re_q;
    assign Entry_time   = entry_time_q;
    assign Ccost        = cost_q;
    assign occupancy    = occ_q;
    assign full         = full_q;
    assign empty        = empty_q;

    // Subtraction wraps modulo 2**TIME_W, so a timebase rollover still yields the true elapsed time.
    always_comb begin
        elapsed  = cap_time_q - slot_time_q[match_idx_q];
        product  = PROD_W'(elapsed) * PROD_W'(RATE);
        fee_wide = WIDE_W'(product);
        if (fee_wide < WIDE_W'(MIN_CHARGE)) fee_wide = WIDE_W'(MIN_CHARGE);
        if (fee_wide > MAX_COST) fee_wide = MAX_COST;
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        op_d          = op_q;
        id_d          = id_q;
        cap_time_d    = cap_time_q;
        free_found_d  = free_found_q;
        free_idx_d    = free_idx_q;
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        slot_valid_d  = slot_valid_q;
        occ_d         = occ_q;
        resp_valid_d  = 1'b0;
        we_d          = 1'b0;
        re_d          = 1'b0;
        status_d      = status_q;
        entry_time_d  = entry_time_q;
        cost_d        = cost_q;
        slot_wr       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d          = op_e'(req_op);
                    id_d          = car_id;
                    cap_time_d    = current_time;
                    idx_d         = '0;
                    free_found_d  = 1'b0;
                    free_idx_d    = '0;
                    match_found_d = 1'b0;
                    match_idx_d   = '0;
                    state_d       = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!free_found_q && !slot_valid_q[idx_q]) begin
                    free_found_d = 1'b1;
                    free_idx_d   = idx_q;
                end
                if (slot_valid_q[idx_q] && (slot_id_q[idx_q] == id_q)) begin
                    match_found_d = 1'b1;
                    match_idx_d   = idx_q;
                end
                if (idx_q == LAST_IDX) state_d = S_COMMIT;
                else                   idx_d   = idx_q + IDX_W'(1);
            end
            S_COMMIT: begin
                resp_valid_d = 1'b1;
                state_d      = S_IDLE;
                entry_time_d = '0;
                cost_d       = '0;
                // A duplicate ID is reported even when the lot is also full.
                if (op_q == OP_ENTRY) begin
                    if (match_found_q) begin
                        status_d = ST_DUP;
                    end else if (!free_found_q) begin
                        status_d = ST_FULL;
                    end else begin
                        status_d                 = ST_OK;
                        slot_wr                  = 1'b1;
                        slot_valid_d[free_idx_q] = 1'b1;
                        we_d                     = 1'b1;
                        entry_time_d             = cap_time_q;
                        occ_d                    = occ_q + OCC_W'(1);
                    end
                end else begin
                    if (!match_found_q) begin
                        status_d = ST_NOT_FOUND;
                    end else begin
                        status_d                  = ST_OK;
                        slot_valid_d[match_idx_q] = 1'b0;
                        re_d                      = 1'b1;
                        entry_time_d              = slot_time_q[match_idx_q];
                        cost_d                    = fee_wide[COST_W-1:0];
                        occ_d                     = occ_q - OCC_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        full_d  = (occ_d == OCC_W'(NUM_SLOTS));
        empty_d = (occ_d == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            op_q          <= OP_ENTRY;
            id_q          <= '0;
            cap_time_q    <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            slot_valid_q  <= '0;
            occ_q         <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            resp_valid_q  <= 1'b0;
            we_q          <= 1'b0;
            re_q          <= 1'b0;
            status_q      <= ST_OK;
            entry_time_q  <= '0;
            cost_q        <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            op_q          <= op_d;
            id_q          <= id_d;
            cap_time_q    <= cap_time_d;
            free_found_q  <= free_found_d;
            free_idx_q    <= free_idx_d;
            match_found_q <= match_found_d;
            match_idx_q   <= match_idx_d;
            slot_valid_q  <= slot_valid_d;
            occ_q         <= occ_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            resp_valid_q  <= resp_valid_d;
            we_q          <= we_d;
            re_q          <= re_d;
            status_q      <= status_d;
            entry_time_q  <= entry_time_d;
            cost_q        <= cost_d;
        end
    end

    // Slot payload needs no reset: it is only read when the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (slot_wr) begin
            slot_id_q[free_idx_q]   <= id_q;
            slot_time_q[free_idx_q] <= cap_time_q;
        end
    end

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Directed bench for parking_lot_ctrl: three instances cover the base config,
// a slow timebase (minimum charge) and an 8-bit timebase with 6-bit fee.
module tb_parking_lot_ctrl;

    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic rstN;
    int   checks = 0;
    int   errors = 0;

    logic       reqValid [NDUT];
    logic       reqOp    [NDUT];
    logic [3:0] carId    [NDUT];

    wire        reqReady   [NDUT];
    wire        respValid  [NDUT];
    wire [1:0]  respStatus [NDUT];
    wire        writeEn    [NDUT];
    wire        readEn     [NDUT];
    wire [31:0] entryTime  [NDUT];
    wire [31:0] cost       [NDUT];
    wire [31:0] curTime    [NDUT];
    wire [2:0]  occupancy  [NDUT];
    wire        isFull     [NDUT];
    wire        isEmpty    [NDUT];

    wire [7:0] wrapEntryTime;
    wire [7:0] wrapCurTime;
    wire [5:0] wrapCost;

    assign entryTime[2] = {24'd0, wrapEntryTime};
    assign curTime[2]   = {24'd0, wrapCurTime};
    assign cost[2]      = {26'd0, wrapCost};

    always #5 clk = ~clk;

    parking_lot_ctrl #(
        .NUM_SLOTS(4), .ID_W(4), .TIME_W(32), .COST_W(32),
        .TICK_DIV(1), .RATE(5), .MIN_CHARGE(10)
    ) dutMain (
        .clk(clk), .reset(rstN),
        .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_op(reqOp[0]), .car_id(carId[0]),
        .resp_valid(respValid[0]), .resp_status(respStatus[0]),
        .write_enable(writeEn[0]), .read_enable(readEn[0]),
        .Entry_time(entryTime[0]), .Ccost(cost[0]), .current_time(curTime[0]),
        .occupancy(occupancy[0]), .full(isFull[0]), .empty(isEmpty[0])
    );

    parking_lot_ctrl #(
        .NUM_SLOTS(4), .ID_W(4), .TIME_W(32), .COST_W(32),
        .TICK_DIV(100), .RATE(5), .MIN_CHARGE(10)
    ) dutTick (
        .clk(clk), .reset(rstN),
        .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_op(reqOp[1]), .car_id(carId[1]),
        .resp_valid(respValid[1]), .resp_status(respStatus[1]),
        .write_enable(writeEn[1]), .read_enable(readEn[1]),
        .Entry_time(entryTime[1]), .Ccost(cost[1]), .current_time(curTime[1]),
        .occupancy(occupancy[1]), .full(isFull[1]), .empty(isEmpty[1])
    );

    parking_lot_ctrl #(
        .NUM_SLOTS(4), .ID_W(4), .TIME_W(8), .COST_W(6),
        .TICK_DIV(1), .RATE(5), .MIN_CHARGE(10)
    ) dutWrap (
        .clk(clk), .reset(rstN),
        .req_valid(reqValid[2]), .req_ready(reqReady[2]), .req_op(reqOp[2]), .car_id(carId[2]),
        .resp_valid(respValid[2]), .resp_status(respStatus[2]),
        .write_enable(writeEn[2]), .read_enable(readEn[2]),
        .Entry_time(wrapEntryTime), .Ccost(wrapCost), .current_time(wrapCurTime),
        .occupancy(occupancy[2]), .full(isFull[2]), .empty(isEmpty[2])
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Waits (bounded) at negedges until the instance's timebase shows t.
    task automatic waitTime(input int d, input logic [31:0] t);
        int n = 0;
        while (curTime[d] !== t && n < 600) begin
            @(negedge clk);
            n++;
        end
        checkOutput($sformatf("dut%0d reaches time %0d", d, t), 32'(n < 600), 32'd1);
    endtask

    // Issues one request at the current negedge and returns at the negedge the response is visible.
    // With spam set, a stray entry request is raised while the controller is busy scanning.
    task automatic applyStimulus(input int d, input logic op, input logic [3:0] id, input bit spam);
        int lat;
        checkOutput($sformatf("dut%0d ready before req", d), 32'(reqReady[d]), 32'd1);
        reqValid[d] = 1'b1;
        reqOp[d]    = op;
        carId[d]    = id;
        @(posedge clk);
        @(negedge clk);
        reqValid[d] = 1'b0;
        lat = 1;
        checkOutput($sformatf("dut%0d busy after accept", d), 32'(reqReady[d]), 32'd0);
        while (!respValid[d] && lat < 20) begin
            if (spam && lat == 2) begin
                reqValid[d] = 1'b1;
                reqOp[d]    = 1'b0;
                carId[d]    = 4'd9;
            end else begin
                reqValid[d] = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        reqValid[d] = 1'b0;
        checkOutput($sformatf("dut%0d response latency", d), 32'(lat), 32'd6);
        checkOutput($sformatf("dut%0d ready at response", d), 32'(reqReady[d]), 32'd1);
    endtask

    task automatic checkResponse(input int d, input string tag, input logic [1:0] st,
                                 input logic we, input logic re, input bit chkTime,
                                 input logic [31:0] et, input logic [31:0] cc, input logic [2:0] occ);
        checkOutput({tag, " resp_valid"}, 32'(respValid[d]), 32'd1);
        checkOutput({tag, " status"}, 32'(respStatus[d]), 32'(st));
        checkOutput({tag, " write_enable"}, 32'(writeEn[d]), 32'(we));
        checkOutput({tag, " read_enable"}, 32'(readEn[d]), 32'(re));
        if (chkTime) checkOutput({tag, " Entry_time"}, entryTime[d], et);
        checkOutput({tag, " Ccost"}, cost[d], cc);
        checkOutput({tag, " occupancy"}, 32'(occupancy[d]), 32'(occ));
        checkOutput({tag, " full"}, 32'(isFull[d]), 32'(occ == 3'd4));
        checkOutput({tag, " empty"}, 32'(isEmpty[d]), 32'(occ == 3'd0));
    endtask

    initial begin
        int pulses;
        for (int i = 0; i < NDUT; i++) begin
            reqValid[i] = 1'b0;
            reqOp[i]    = 1'b0;
            carId[i]    = 4'd0;
        end
        rstN = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("reset req_ready", 32'(reqReady[0]), 32'd1);
        checkOutput("reset resp_valid", 32'(respValid[0]), 32'd0);
        checkOutput("reset write_enable", 32'(writeEn[0]), 32'd0);
        checkOutput("reset read_enable", 32'(readEn[0]), 32'd0);
        checkOutput("reset status", 32'(respStatus[0]), 32'd0);
        checkOutput("reset Entry_time", entryTime[0], 32'd0);
        checkOutput("reset Ccost", cost[0], 32'd0);
        checkOutput("reset current_time", curTime[0], 32'd0);
        checkOutput("reset occupancy", 32'(occupancy[0]), 32'd0);
        checkOutput("reset empty", 32'(isEmpty[0]), 32'd1);
        checkOutput("reset full", 32'(isFull[0]), 32'd0);
        rstN = 1'b1;

        // Basic entry at t=3 and exit at t=20: fee 17*5.
        waitTime(0, 32'd3);
        applyStimulus(0, 1'b0, 4'd1, 1'b0);
        checkResponse(0, "entry id1", 2'd0, 1'b1, 1'b0, 1'b1, 32'd3, 32'd0, 3'd1);
        waitTime(0, 32'd20);
        applyStimulus(0, 1'b1, 4'd1, 1'b1);
        checkResponse(0, "exit id1", 2'd0, 1'b0, 1'b1, 1'b1, 32'd3, 32'd85, 3'd0);
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (respValid[0]) pulses++;
        end
        checkOutput("busy request ignored", 32'(pulses), 32'd0);
        checkOutput("occupancy after ignored req", 32'(occupancy[0]), 32'd0);

        // Slow timebase: entry and exit inside one time unit pay the minimum charge.
        waitTime(1, 32'd1);
        applyStimulus(1, 1'b0, 4'd1, 1'b0);
        checkResponse(1, "tick entry", 2'd0, 1'b1, 1'b0, 1'b1, 32'd1, 32'd0, 3'd1);
        applyStimulus(1, 1'b1, 4'd1, 1'b0);
        checkResponse(1, "tick exit min charge", 2'd0, 1'b0, 1'b1, 1'b1, 32'd1, 32'd10, 3'd0);

        // Fill the lot, then the rejections.
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 1'b0, 4'(i), 1'b0);
            checkResponse(0, $sformatf("fill id%0d", i), 2'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 3'(i));
        end
        applyStimulus(0, 1'b0, 4'd5, 1'b0);
        checkResponse(0, "entry when full", 2'd1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd4);
        applyStimulus(0, 1'b0, 4'd2, 1'b0);
        checkResponse(0, "duplicate over full", 2'd2, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd4);
        applyStimulus(0, 1'b1, 4'd9, 1'b0);
        checkResponse(0, "exit absent id9", 2'd3, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 3'd4);

        // Free-slot reuse.
        applyStimulus(0, 1'b1, 4'd1, 1'b0);
        checkOutput("reuse exit status", 32'(respStatus[0]), 32'd0);
        checkOutput("reuse exit occupancy", 32'(occupancy[0]), 32'd3);
        applyStimulus(0, 1'b0, 4'd7, 1'b0);
        checkResponse(0, "reuse entry id7", 2'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd4);
        applyStimulus(0, 1'b0, 4'd8, 1'b0);
        checkResponse(0, "full again", 2'd1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd4);

        // 8-bit timebase wrap: 250 -> 4 is 10 units; 20 units saturates the 6-bit fee.
        waitTime(2, 32'd250);
        applyStimulus(2, 1'b0, 4'd3, 1'b0);
        checkResponse(2, "wrap entry", 2'd0, 1'b1, 1'b0, 1'b1, 32'd250, 32'd0, 3'd1);
        waitTime(2, 32'd4);
        applyStimulus(2, 1'b1, 4'd3, 1'b0);
        checkResponse(2, "wrap exit", 2'd0, 1'b0, 1'b1, 1'b1, 32'd250, 32'd50, 3'd0);
        waitTime(2, 32'd30);
        applyStimulus(2, 1'b0, 4'd5, 1'b0);
        checkResponse(2, "sat entry", 2'd0, 1'b1, 1'b0, 1'b1, 32'd30, 32'd0, 3'd1);
        waitTime(2, 32'd50);
        applyStimulus(2, 1'b1, 4'd5, 1'b0);
        checkResponse(2, "sat exit", 2'd0, 1'b0, 1'b1, 1'b1, 32'd30, 32'd63, 3'd0);

        // Reset while an entry for id6 is scanning.
        reqValid[0] = 1'b1;
        reqOp[0]    = 1'b0;
        carId[0]    = 4'd6;
        @(posedge clk);
        @(negedge clk);
        reqValid[0] = 1'b0;
        @(negedge clk);
        rstN = 1'b0;
        #1;
        checkOutput("midreset resp_valid", 32'(respValid[0]), 32'd0);
        checkOutput("midreset occupancy", 32'(occupancy[0]), 32'd0);
        checkOutput("midreset current_time", curTime[0], 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("ready after reset release", 32'(reqReady[0]), 32'd1);
        pulses = 0;
        repeat (8) begin
            if (respValid[0]) pulses++;
            @(negedge clk);
        end
        checkOutput("no response after abort", 32'(pulses), 32'd0);
        applyStimulus(0, 1'b1, 4'd6, 1'b0);
        checkResponse(0, "exit aborted id6", 2'd3, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
